// File: rtl/reset_pkg.sv
// Shared types for the reset-request block: FSM states, cause mask layout, bit indices.
package reset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } rst_req_state_e;

  typedef struct packed {
    logic dbg;
    logic wdt;
    logic sw;
  } rst_cause_t;

  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WDT = 1;
  localparam int CAUSE_DBG = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_wdt.sv
// Watchdog counter: decrements while enabled, reloads on kick or timeout; the
// reload register only feeds the counter at the next kick/timeout.
module reset_wdt #(
  parameter int WDT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 kick_i,
  input  logic                 load_i,
  input  logic [WDT_WIDTH-1:0] load_val_i,
  output logic                 timeout_o,
  output logic [WDT_WIDTH-1:0] count_o
);

  logic [WDT_WIDTH-1:0] count_q, count_d;
  logic [WDT_WIDTH-1:0] reload_q, reload_d;

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    timeout_o = 1'b0;
    if (load_i) begin
      reload_d = load_val_i;
    end
    // Kick has priority over both decrement and timeout.
    if (kick_i) begin
      count_d = reload_q;
    end else if (en_i) begin
      if (count_q == '0) begin
        timeout_o = 1'b1;
        count_d   = reload_q;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '1;
      reload_q <= '1;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reset_request.sv
// Reset-request initiator: qualifies sw/wdt/debug requests, emits one fixed low
// pulse on rst_req_n_o followed by a holdoff, and keeps a sticky cause mask.
// Optional debug source enabled by defining RESET_REQ_DEBUG_EN.
module reset_request
  import reset_pkg::*;
#(
  parameter int          PULSE_CYCLES   = 16,
  parameter int          HOLDOFF_CYCLES = 64,
  parameter int          WDT_WIDTH      = 32,
  parameter logic [31:0] SW_KEY         = 32'hA5A5_5A5A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_req_i,
  input  logic [31:0]          sw_key_i,
  input  logic                 wdt_en_i,
  input  logic                 wdt_kick_i,
  input  logic                 wdt_load_i,
  input  logic [WDT_WIDTH-1:0] wdt_load_val_i,
`ifdef RESET_REQ_DEBUG_EN
  input  logic                 dbg_req_i,
`endif
  input  logic                 cause_clr_i,
  output logic                 rst_req_n_o,
  output logic                 busy_o,
  output logic [2:0]           cause_o,
  output logic [WDT_WIDTH-1:0] wdt_count_o,
  output rst_req_state_e       state_o
);

  localparam int CNT_MAX = max2(PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  rst_req_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rst_req_n_q, rst_req_n_d;
  rst_cause_t     cause_d;
  // Deliberately outside the reset path: must survive the reset it triggers.
  rst_cause_t     cause_q = '0;

  logic       wdt_timeout;
  logic       dbg_req;
  rst_cause_t req_mask;
  logic       any_req;

  reset_wdt #(
    .WDT_WIDTH (WDT_WIDTH)
  ) u_wdt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (wdt_en_i),
    .kick_i     (wdt_kick_i),
    .load_i     (wdt_load_i),
    .load_val_i (wdt_load_val_i),
    .timeout_o  (wdt_timeout),
    .count_o    (wdt_count_o)
  );

`ifdef RESET_REQ_DEBUG_EN
  assign dbg_req = dbg_req_i;
`else
  assign dbg_req = 1'b0;
`endif

  always_comb begin
    req_mask     = '0;
    req_mask.sw  = sw_req_i && (sw_key_i == SW_KEY);
    req_mask.wdt = wdt_timeout;
    req_mask.dbg = dbg_req;
    any_req      = |req_mask;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (cause_clr_i) begin
      cause_d = '0;
    end
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ASSERT;
          cnt_d   = '0;
          cause_d = req_mask;
        end
      end
      ASSERT: begin
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered so the request line is a clean flop output.
    rst_req_n_d = (state_d != ASSERT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rst_req_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_req_n_q <= rst_req_n_d;
    end
  end

  always_ff @(posedge clk) begin
    cause_q <= cause_d;
  end

  assign rst_req_n_o = rst_req_n_q;
  assign busy_o      = (state_q != IDLE);
  assign cause_o     = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_reset_request.sv
// Directed bench for reset_request: pulse width, holdoff, key check, watchdog,
// simultaneous sources, reset mid-pulse and cause register behaviour.
module tb_reset_request;
  import reset_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           sw_req = 1'b0;
  logic [31:0]    sw_key = '0;
  logic           wdt_en = 1'b0;
  logic           wdt_kick = 1'b0;
  logic           wdt_load = 1'b0;
  logic [31:0]    wdt_load_val = '0;
  logic           dbg_req = 1'b0;
  logic           cause_clr = 1'b0;
  logic           rst_req_n;
  logic           busy;
  logic [2:0]     cause;
  logic [31:0]    wdt_count;
  rst_req_state_e state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  reset_request dut (
    .clk            (clk),
    .rst            (rst),
    .sw_req_i       (sw_req),
    .sw_key_i       (sw_key),
    .wdt_en_i       (wdt_en),
    .wdt_kick_i     (wdt_kick),
    .wdt_load_i     (wdt_load),
    .wdt_load_val_i (wdt_load_val),
`ifdef RESET_REQ_DEBUG_EN
    .dbg_req_i      (dbg_req),
`endif
    .cause_clr_i    (cause_clr),
    .rst_req_n_o    (rst_req_n),
    .busy_o         (busy),
    .cause_o        (cause),
    .wdt_count_o    (wdt_count),
    .state_o        (state)
  );

  // Clock / time limit
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sw_request(input logic [31:0] key);
    sw_req = 1'b1;
    sw_key = key;
    step();
    sw_req = 1'b0;
  endtask

  // Counts low and busy cycles over a fixed window; optional sw request at inject_at.
  task automatic measure(input int inject_at, output int lows, output int busys);
    lows  = 0;
    busys = 0;
    for (int i = 0; i < 200; i++) begin
      if (!rst_req_n) lows++;
      if (busy) busys++;
      if (i == inject_at) begin
        sw_req = 1'b1;
        sw_key = KEY;
      end
      step();
      sw_req = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) step();
    chk(tag, busy, 0);
  endtask

  initial begin
    int lows;
    int busys;
    int cycles;

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_req_n", rst_req_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cause", cause, 0);
    chk("rst_wdt_count", wdt_count, 32'hFFFF_FFFF);
    chk("rst_state", state, IDLE);

    // Valid software request
    exp_q.push_back(16);
    sw_request(KEY);
    chk("sw_latency", rst_req_n, 0);
    measure(-1, lows, busys);
    chk("sw_pulse_len", lows, exp_q.pop_front());
    chk("sw_busy_len", busys, 80);
    chk("sw_cause", cause, 3'b001);

    // Wrong key ignored
    sw_request(32'h0);
    chk("badkey_n", rst_req_n, 1);
    chk("badkey_busy", busy, 0);
    chk("badkey_cause", cause, 3'b001);
    step();
    chk("badkey_n2", rst_req_n, 1);

    // Watchdog timeout
    wdt_load_val = 32'd10;
    wdt_load = 1'b1;
    step();
    wdt_load = 1'b0;
    chk("wdt_load_deferred", wdt_count, 32'hFFFF_FFFF);
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    chk("wdt_kick_reload", wdt_count, 10);
    wdt_en = 1'b1;
    cycles = 0;
    for (int i = 0; i < 20 && rst_req_n; i++) begin
      step();
      cycles++;
    end
    chk("wdt_timeout_cycles", cycles, 11);
    chk("wdt_reload_on_to", wdt_count, 10);
    wdt_en = 1'b0;
    chk("wdt_cause", cause, 3'b010);
    wait_idle("wdt_idle");

    // Regular kicks keep the watchdog from firing
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    wdt_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 5 == 4) wdt_kick = 1'b1;
      step();
      wdt_kick = 1'b0;
      if (!rst_req_n) lows++;
    end
    chk("wdt_kicked_lows", lows, 0);
    wdt_en = 1'b0;
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    repeat (3) step();
    chk("wdt_frozen", wdt_count, 10);

    // Simultaneous sw + wdt, then sw during holdoff dropped
    wdt_kick = 1'b1;
    step();
    wdt_kick = 1'b0;
    wdt_en = 1'b1;
    repeat (10) step();
    chk("wdt_at_zero", wdt_count, 0);
    exp_q.push_back(16);
    sw_request(KEY);
    wdt_en = 1'b0;
    measure(30, lows, busys);
    chk("both_pulse_len", lows, exp_q.pop_front());
    chk("both_busy_len", busys, 80);
    chk("both_cause", cause, 3'b011);

    // Reset in the middle of a pulse
    sw_request(KEY);
    repeat (4) step();
    chk("mid_pulse_n", rst_req_n, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_n", rst_req_n, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_state", state, IDLE);
    chk("midrst_cause", cause, 3'b001);
    chk("midrst_wdt", wdt_count, 32'hFFFF_FFFF);
    exp_q.push_back(16);
    sw_request(KEY);
    measure(-1, lows, busys);
    chk("post_rst_pulse_len", lows, exp_q.pop_front());
    chk("post_rst_busy_len", busys, 80);

`ifdef RESET_REQ_DEBUG_EN
    // Debug source
    dbg_req = 1'b1;
    step();
    dbg_req = 1'b0;
    chk("dbg_cause", cause, 3'b100);
    chk("dbg_n", rst_req_n, 0);
    wait_idle("dbg_idle");
`endif

    // Cause clear, and event beating a same-cycle clear
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("clr_cause", cause, 0);
    cause_clr = 1'b1;
    sw_request(KEY);
    cause_clr = 1'b0;
    chk("clr_vs_event", cause, 3'b001);
    wait_idle("clr_idle");
    cause_clr = 1'b1;
    step();
    cause_clr = 1'b0;
    chk("clr_final", cause, 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
